instruction_fetch_controller: RTL and testbench
===============================================

// Module: instruction_fetch_controller
// PURPOSE
//  Sequences the asynchronous-read program memory ROM: owns the PC, drives the ROM byte address,
//  captures each instruction into a 2-entry fetch buffer, and hands {instr, pc} to decode over a
//  valid/ready handshake. Handles branch/jump redirects, stalls and out-of-range fetch faults.
//  Sits between the program memory and the decode/register-file stage of the MIPS core.
// PARAMETERS
//  DATA_WIDTH    32            width of PC, address and instruction
//  MEMORY_DEPTH  32            ROM depth in words; legal offsets 0 .. 4*MEMORY_DEPTH-4
//  PC_BASE       32'h00400000  PC of ROM word 0 (text segment base); also reset PC
// PORTS
//  clk            in   1           rising-edge clock
//  reset          in   1           asynchronous, active-low reset
//  start          in   1           leave IDLE and begin fetching (level, sampled in IDLE)
//  imem_addr      out  DATA_WIDTH  byte address to ROM = pc - PC_BASE (ROM drops bits [1:0])
//  imem_instr     in   DATA_WIDTH  ROM data, valid same cycle as imem_addr (combinational read)
//  out_valid      out  1           buffer head holds a valid instruction
//  out_ready      in   1           decode accepts head this cycle
//  out_instr      out  DATA_WIDTH  head instruction
//  out_pc         out  DATA_WIDTH  head PC
//  redirect_valid in   1           branch/jump taken; flush and refetch
//  redirect_pc    in   DATA_WIDTH  new PC
//  fault          out  1           FSM in FAULT
//  fault_pc       out  DATA_WIDTH  PC that caused the fault
// BEHAVIOUR
//  - Reset (async assert, sync-to-clk deassert effect): state=IDLE, pc=PC_BASE, buffer count=0,
//    out_valid=0, out_instr=0, out_pc=0, fault=0, fault_pc=0, imem_addr=0.
//  - FSM: IDLE --start--> RUN; RUN --illegal fetch--> FAULT; FAULT --redirect_valid--> RUN
//    (or FAULT again if redirect_pc illegal); IDLE ignores redirect. Only reset returns to IDLE.
//  - Legal PC: pc[1:0]==0 and PC_BASE <= pc <= PC_BASE+4*MEMORY_DEPTH-4 (unsigned compare).
//  - pop  = out_valid & out_ready. fetch = RUN & legal pc & (count<2 | pop) & ~redirect_valid.
//  - fetch: push {imem_instr, pc} at tail, pc <= pc+4 at the same edge. One instruction per cycle
//    max; fetch-to-out_valid latency 1 cycle (registered buffer, no bypass).
//  - Full buffer with pop: pop and push same edge, count stays 2, order preserved.
//  - Empty buffer with out_ready high: nothing popped; out_valid stays 0.
//  - RUN & count<2 & pc illegal: no push, state<=FAULT, fault_pc<=pc; already-buffered entries
//    stay poppable in FAULT.
//  - redirect_valid (RUN or FAULT): highest priority; buffer flushed (count<=0, pop ignored even if
//    out_ready), no push, pc<=redirect_pc; out_valid=0 next cycle, earliest new out_valid 2 cycles
//    after the redirect edge. Illegal redirect_pc -> FAULT next fetch attempt, fault_pc=redirect_pc.
//  - pc wraps at 2^DATA_WIDTH only arithmetically; wrap result is illegal -> FAULT.
//  - imem_addr = pc - PC_BASE in every state after reset (may be out of range; ROM output ignored).
//  - Reset mid-operation: all state discarded immediately, no partial handshake completes.
// CONFIGURATION
//  FETCH_PERF_COUNTERS_EN defined: adds outputs fetch_count[31:0] (increments per push) and
//    stall_count[31:0] (increments each RUN cycle with count==2 & ~pop); both reset to 0, saturate
//    at 32'hFFFFFFFF, cleared by reset only.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 reset low, start=1, out_ready=1, ROM[k]=k+0x100 -> from 2nd cycle after start one instr/cycle,
//    out_pc 0x00400000,04,08.., out_instr 0x100,0x101,..
//  2 out_ready=0 for 5 cycles after start -> count saturates at 2, pc=0x00400008 held, out_pc=0x00400000
//    stable; out_ready=1 -> 0x00400000, 04, 08 delivered in order, no gap/dup.
//  3 redirect_valid with redirect_pc=0x00400040 while count==2 and out_ready=1 -> no pop that edge,
//    out_valid=0 next cycle, then out_pc=0x00400040, instr ROM[16].
//  4 MEMORY_DEPTH=32, run to pc=0x00400080 -> fault=1, fault_pc=0x00400080, last out_pc=0x0040007C
//    still delivered; redirect to 0x00400000 -> fault=0, fetch resumes.
//  5 redirect_pc=0x00400002 (misaligned) -> FAULT, fault_pc=0x00400002, no instruction pushed.
//  6 assert reset mid-stream with count==2 -> out_valid=0, pc=0x00400000, state IDLE same instant;
//    with FETCH_PERF_COUNTERS_EN, test 2 shows stall_count=3, fetch_count tracks pushes.

Source files
------------

// File: rtl/instruction_fetch_controller.sv
// instruction_fetch_controller: owns the PC, sequences the ROM, buffers two fetches for decode.
// Define FETCH_PERF_COUNTERS_EN to add the fetch_count / stall_count outputs.
module instruction_fetch_controller #(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] PC_BASE      = 32'h00400000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [DATA_WIDTH-1:0] out_pc,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  fault,
  output logic [DATA_WIDTH-1:0] fault_pc
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]           fetch_count,
  output logic [31:0]           stall_count
`endif
);

  localparam logic [DATA_WIDTH-1:0] PC_STEP =
    DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] PC_LAST =
    PC_BASE + DATA_WIDTH'(4 * MEMORY_DEPTH - 4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FAULT
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
  } fb_entry_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] fpc;
  logic [1:0]            count;
  fb_entry_t             head;
  fb_entry_t             tail;
  fb_entry_t             fresh;

  logic running;
  logic legal;
  logic room;
  logic pop;
  logic flush;
  logic fetch;
  logic trap;
  logic push_pop;
  logic push_only;
  logic pop_only;

  assign running = (state == S_RUN);

  assign legal = (pc[1:0] == 2'b00)
               && (pc >= PC_BASE)
               && (pc <= PC_LAST);

  assign room  = (count < 2'd2);
  assign pop   = out_valid & out_ready;
  assign flush = redirect_valid
               & (state != S_IDLE);

  assign fetch = running & legal
               & (room | pop)
               & ~redirect_valid;

  // an illegal PC only faults once there is a slot it could have filled
  assign trap  = running & ~legal
               & room
               & ~redirect_valid;

  assign push_pop  = fetch & pop;
  assign push_only = fetch & ~pop;
  assign pop_only  = pop & ~fetch & ~flush;

  assign fresh.instr = imem_instr;
  assign fresh.pc    = pc;

  assign imem_addr = pc - PC_BASE;
  assign out_valid = (count != 2'd0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign fault     = (state == S_FAULT);
  assign fault_pc  = fpc;

  // control FSM: state, PC and captured fault address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      pc    <= PC_BASE;
      fpc   <= '0;
    end else begin
      unique case (1'b1)
        (state == S_IDLE): begin
          if (start) state <= S_RUN;
        end
        flush: begin
          state <= S_RUN;
          pc    <= redirect_pc;
        end
        fetch: begin
          pc <= pc + PC_STEP;
        end
        trap: begin
          state <= S_FAULT;
          fpc   <= pc;
        end
        default: ;
      endcase
    end
  end

  // two-entry fetch buffer; head feeds decode directly
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      unique case (1'b1)
        flush: begin
          count <= 2'd0;
        end
        push_pop: begin
          if (count == 2'd2) begin
            head <= tail;
            tail <= fresh;
          end else begin
            head <= fresh;
          end
        end
        push_only: begin
          if (count == 2'd0) head <= fresh;
          else tail <= fresh;
          count <= count + 2'd1;
        end
        pop_only: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  logic stall;

  assign stall = running
               & (count == 2'd2)
               & ~pop;

  // saturating push and back-pressure counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (fetch && fetch_count != '1)
        fetch_count <= fetch_count + 32'd1;
      if (stall && stall_count != '1)
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// tb_instruction_fetch_controller: directed + random stimulus
// against a queue-based reference of the fetch rules.
`timescale 1ns/1ps
module tb_instruction_fetch_controller;

  localparam logic [31:0] BASE  = 32'h00400000;
  localparam int          DEPTH = 32;
  localparam logic [31:0] LAST  = BASE + 32'(4 * DEPTH - 4);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] fault_pc;
  logic        out_valid;
  logic        fault;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  instruction_fetch_controller #(
    .DATA_WIDTH   (32),
    .MEMORY_DEPTH (DEPTH),
    .PC_BASE      (BASE)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fault          (fault),
    .fault_pc       (fault_pc)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
`endif
  );

  always #5 clk = ~clk;

  // ROM: word k holds k + 0x100
  always_comb begin
    if (imem_addr < 32'(4 * DEPTH))
      imem_instr = 32'h100 + (imem_addr >> 2);
    else
      imem_instr = 32'hDEADBEEF;
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  int          mstate;
  logic [31:0] mpc;
  logic [31:0] mfpc;
  logic [31:0] mfetch;
  logic [31:0] mstall;
  int          nchk = 0;
  int          nerr = 0;

  function automatic bit legal(input logic [31:0] p);
    return (p[1:0] == 2'b00) && (p >= BASE) && (p <= LAST);
  endfunction

  task automatic mreset();
    q.delete();
    mstate = 0;
    mpc    = BASE;
    mfpc   = '0;
    mfetch = '0;
    mstall = '0;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check("imem_addr", imem_addr, mpc - BASE);
    check("fault", 32'(fault), 32'(mstate == 2));
    check("fault_pc", fault_pc, mfpc);
    if (q.size() > 0) begin
      check("out_pc", out_pc, q[0].pc);
      check("out_instr", out_instr, q[0].instr);
    end
`ifdef FETCH_PERF_COUNTERS_EN
    check("fetch_count", fetch_count, mfetch);
    check("stall_count", stall_count, mstall);
`endif
  endtask

  // one clock edge of the reference: 0 idle, 1 run, 2 fault
  task automatic mstep(input bit s, input bit r,
                       input bit rv, input logic [31:0] rp);
    int n;
    bit pop;
    n   = q.size();
    pop = (n > 0) && r;
    if (mstate == 0) begin
      if (s) mstate = 1;
      return;
    end
    if (mstate == 1 && n == 2 && !pop && mstall != '1)
      mstall++;
    if (rv) begin
      q.delete();
      mpc    = rp;
      mstate = 1;
      return;
    end
    if (pop) void'(q.pop_front());
    if (mstate == 1 && legal(mpc) && (n < 2 || pop)) begin
      q.push_back('{instr: 32'h100 + ((mpc - BASE) >> 2), pc: mpc});
      mpc = mpc + 32'd4;
      if (mfetch != '1) mfetch++;
    end else if (mstate == 1 && !legal(mpc) && n < 2) begin
      mstate = 2;
      mfpc   = mpc;
    end
  endtask

  task automatic cyc(input bit s, input bit r,
                     input bit rv, input logic [31:0] rp);
    start          = s;
    out_ready      = r;
    redirect_valid = rv;
    redirect_pc    = rp;
    #2;
    compare_all();
    mstep(s, r, rv, rp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mreset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  function automatic logic [31:0] rand_pc();
    case ($urandom_range(0, 5))
      0, 1, 2: return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      3:       return LAST;
      4:       return BASE + 32'(4 * $urandom_range(0, DEPTH - 1))
                      + 32'($urandom_range(1, 3));
      default: return ($urandom_range(0, 1) != 0) ? LAST + 32'd4
                                                  : BASE - 32'd4;
    endcase
  endfunction

  initial begin
    mreset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    compare_all();
    reset = 1'b1;

    // streaming with decode always ready
    cyc(1, 1, 0, '0);
    cyc(1, 1, 0, '0);
    check("t1_pc0", out_pc, BASE);
    check("t1_instr0", out_instr, 32'h100);
    for (int i = 0; i < 6; i++) cyc(1, 1, 0, '0);

    // back-pressure fills the buffer
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, '0);
    check("t2_pc_held", imem_addr, 32'h8);
    check("t2_head", out_pc, BASE);
`ifdef FETCH_PERF_COUNTERS_EN
    check("t2_stalls", stall_count, 32'd3);
`endif
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, '0);

    // redirect against a full buffer
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, '0);
    cyc(1, 1, 1, BASE + 32'h40);
    check("t3_flushed", 32'(out_valid), 32'd0);
    cyc(1, 1, 0, '0);
    check("t3_pc", out_pc, BASE + 32'h40);
    check("t3_instr", out_instr, 32'h110);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, '0);

    // run off the end of the ROM, then recover
    cyc(1, 1, 1, BASE + 32'h70);
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, '0);
    check("t4_fault", 32'(fault), 32'd1);
    check("t4_fault_pc", fault_pc, BASE + 32'h80);
    cyc(1, 1, 1, BASE);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, '0);
    check("t4_recovered", 32'(fault), 32'd0);

    // misaligned redirect
    cyc(1, 1, 1, BASE + 32'h2);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, '0);
    check("t5_fault", 32'(fault), 32'd1);
    check("t5_fault_pc", fault_pc, BASE + 32'h2);
    check("t5_empty", 32'(out_valid), 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      cyc($urandom_range(0, 7) != 0,
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 9) == 0,
          rand_pc());
    end

    // asynchronous reset with a full buffer
    cyc(1, 1, 1, BASE + 32'h20);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, '0);
    check("t6_full", 32'(out_valid), 32'd1);
    reset = 1'b0;
    #1;
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_addr", imem_addr, 32'h0);
    check("t6_fault", 32'(fault), 32'd0);
    mreset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, '0);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
